// File: rtl/gate_drv.sv
// Half-bridge gate driver: turns the selected oscillation into complementary gate
// signals with dead time, edge-synchronous burst gating, burst/edge watchdogs and OCD latch.
module gate_drv #(
  parameter int CLK_MHZ         = 100,
  parameter int DEAD_TIME_NS    = 100,
  parameter int MAX_ON_US       = 200,
  parameter int EDGE_TIMEOUT_US = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic en,
  input  logic ocd,
  output logic out_a,
  output logic out_b,
  output logic busy,
  output logic fault
);

  localparam int DT_CNT  = CLK_MHZ * DEAD_TIME_NS / 1000;
  localparam int MAX_CNT = CLK_MHZ * MAX_ON_US;
  localparam int TO_CNT  = CLK_MHZ * EDGE_TIMEOUT_US;
  localparam int DT_W    = (DT_CNT > 1) ? $clog2(DT_CNT) : 1;
  localparam int MAX_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int TO_W    = (TO_CNT > 1) ? $clog2(TO_CNT) : 1;

  if (DT_CNT < 1) begin : g_dt_chk
    $error("gate_drv: dead time must be at least one clock");
  end

  typedef enum logic [2:0] {IDLE, DEAD, DRIVE_A, DRIVE_B, FAULT} state_t;

  state_t           state_r;
  logic             sig_r, sig_prev_r, en_r, ocd_r;
  logic             stop_r, lock_r;
  logic [DT_W-1:0]  dt_cnt_r;
  logic [MAX_W-1:0] burst_cnt_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic             edge_s, burst_end_s, stop_s, timeout_s;

  // Input synchronisation and edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_r      <= 1'b0;
      sig_prev_r <= 1'b0;
      en_r       <= 1'b0;
      ocd_r      <= 1'b0;
    end else begin
      sig_r      <= sig;
      sig_prev_r <= sig_r;
      en_r       <= en;
      ocd_r      <= ocd;
    end
  end

  // Decode of edge, burst stop and watchdog conditions
  always_comb begin
    edge_s      = sig_r ^ sig_prev_r;
    burst_end_s = (burst_cnt_r == MAX_W'(MAX_CNT - 1));
    stop_s      = stop_r | ~en_r | burst_end_s;
    timeout_s   = (to_cnt_r == TO_W'(TO_CNT - 1));
  end

  // Gate FSM; lock_r holds off a restart after a watchdog stop until en is released
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      out_a       <= 1'b0;
      out_b       <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      stop_r      <= 1'b0;
      lock_r      <= 1'b0;
      dt_cnt_r    <= '0;
      burst_cnt_r <= '0;
      to_cnt_r    <= '0;
    end else if (ocd_r && (state_r != FAULT)) begin
      state_r <= FAULT;
      out_a   <= 1'b0;
      out_b   <= 1'b0;
      busy    <= 1'b0;
      fault   <= 1'b1;
      stop_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_a <= 1'b0;
          out_b <= 1'b0;
          if (!en_r) begin
            lock_r <= 1'b0;
            busy   <= 1'b0;
          end else if (!lock_r) begin
            state_r     <= DEAD;
            busy        <= 1'b1;
            dt_cnt_r    <= DT_W'(DT_CNT - 1);
            burst_cnt_r <= '0;
            to_cnt_r    <= '0;
            stop_r      <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end
        DEAD: begin
          busy <= 1'b1;
          if (dt_cnt_r == DT_W'(0)) begin
            to_cnt_r <= '0;
            if (sig_r) begin
              state_r <= DRIVE_A;
              out_a   <= 1'b1;
              out_b   <= 1'b0;
            end else begin
              state_r <= DRIVE_B;
              out_a   <= 1'b0;
              out_b   <= 1'b1;
            end
          end else begin
            dt_cnt_r <= dt_cnt_r - DT_W'(1);
          end
        end
        DRIVE_A, DRIVE_B: begin
          if (!burst_end_s) begin
            burst_cnt_r <= burst_cnt_r + MAX_W'(1);
          end
          if (edge_s) begin
            out_a    <= 1'b0;
            out_b    <= 1'b0;
            to_cnt_r <= '0;
            if (stop_s) begin
              state_r <= IDLE;
              busy    <= 1'b0;
              stop_r  <= 1'b0;
              lock_r  <= burst_end_s;
            end else begin
              state_r  <= DEAD;
              busy     <= 1'b1;
              dt_cnt_r <= DT_W'(DT_CNT - 1);
            end
          end else if (timeout_s) begin
            state_r  <= IDLE;
            out_a    <= 1'b0;
            out_b    <= 1'b0;
            busy     <= 1'b0;
            stop_r   <= 1'b0;
            lock_r   <= 1'b1;
            to_cnt_r <= '0;
          end else begin
            busy     <= 1'b1;
            stop_r   <= stop_s;
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        FAULT: begin
          out_a <= 1'b0;
          out_b <= 1'b0;
          busy  <= 1'b0;
          if (!ocd_r && !en_r) begin
            state_r <= IDLE;
            fault   <= 1'b0;
          end else begin
            fault   <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          out_a   <= 1'b0;
          out_b   <= 1'b0;
          busy    <= 1'b0;
          stop_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/gate_drv.md
Name: gate_drv

Overview:
- Output stage downstream of the gen/fb selector in the DRSSTC controller.
- Converts the selected oscillation into two complementary half-bridge gate signals (out_a, out_b) with programmable dead time.
- Gates bursts with the interrupter enable and turns off only at signal edges, so switching happens at zero current.
- Provides a burst-length limit, a missing-edge watchdog and a latched over-current shutdown.

Parameters:
- CLK_MHZ, 100, clock frequency in MHz.
- DEAD_TIME_NS, 100, dead time between gate phases. DT_CNT = CLK_MHZ*DEAD_TIME_NS/1000; DT_CNT must be at least 1.
- MAX_ON_US, 200, maximum burst length. MAX_CNT = CLK_MHZ*MAX_ON_US.
- EDGE_TIMEOUT_US, 4, maximum time without a sig edge while driving. TO_CNT = CLK_MHZ*EDGE_TIMEOUT_US.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sig  input  1  selected oscillation (selector out).
- en  input  1  interrupter burst enable.
- ocd  input  1  over-current detect, active high.
- out_a  output  1  gate drive, phase A (conducts while sig high).
- out_b  output  1  gate drive, phase B (conducts while sig low).
- busy  output  1  high in any state other than IDLE and FAULT.
- fault  output  1  latched over-current flag.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - On rst: state=IDLE; out_a=out_b=busy=fault=0; all counters cleared; stop flag cleared.
- Input registers:
  - sig, en and ocd are each registered once (sig_r, en_r, ocd_r).
  - A sig edge is detected when sig_r differs from its previous value.
- Outputs:
  - All outputs are registered.
  - Invariant: out_a & out_b is never 1, including across reset and fault.
- States: IDLE, DEAD, DRIVE_A, DRIVE_B, FAULT.
- IDLE:
  - Both outputs low.
  - When en_r=1: enter DEAD, load dead counter with DT_CNT-1, clear burst counter.
- DEAD:
  - Both outputs low; dead counter decrements.
  - At counter==0: go to DRIVE_A if sig_r=1, else DRIVE_B, using sig_r sampled in that cycle.
  - Edges of sig during DEAD do not restart the counter.
- DRIVE_A / DRIVE_B:
  - The matching output is high; the burst counter and edge-timeout counter increment.
  - Stop flag is set when en_r=0 or the burst counter reaches MAX_CNT-1.
  - On a sig edge with the stop flag clear: both outputs low, enter DEAD, reload the dead counter, clear the edge-timeout counter.
  - On a sig edge with the stop flag set: both outputs low, enter IDLE, clear the stop flag.
  - If en re-asserts before that edge, the burst still ends. A new burst needs en_r=1 observed in IDLE.
  - If the edge-timeout counter reaches TO_CNT-1: both outputs low, enter IDLE immediately, no edge needed.
- Timing:
  - Let sig change before clock edge k, so sig_r updates at edge k.
  - The active output falls at edge k+1.
  - The opposite output rises at edge k+1+DT_CNT.
- FAULT entry and exit:
  - ocd_r=1 in any state other than IDLE or FAULT forces outputs low at the next edge and enters FAULT with fault=1.
  - ocd_r=1 has priority over every other transition in the same cycle.
  - In IDLE, ocd_r=1 also enters FAULT.
  - FAULT is left to IDLE only when ocd_r=0 and en_r=0 in the same cycle; fault then clears.
- Reset mid-burst: outputs drop at the reset edge, with no dead-time or edge wait.
- Counter widths: $clog2 of each maximum count. The burst counter saturates and never wraps.

Test Plan (CLK_MHZ=100, DT_CNT=10, sig = 500 kHz square, 100 cycles per half-period):
- rst held 5 cycles, then released with en=0 and sig toggling -> out_a=out_b=busy=fault=0 throughout.
- en rises while sig=1 -> out_a rises 1+10 cycles after en_r; first sig fall at edge k -> out_a falls at k+1, out_b rises at k+11; 1 and 0 never overlap.
- en falls mid-phase while out_b=1 -> out_b stays high until the next sig edge, then both outputs low and busy=0; out_a never asserts.
- en held high with MAX_ON_US=2 (MAX_CNT=200) -> burst stops at the first sig edge after 200 drive cycles; en must drop and rise again to restart.
- sig frozen high for 500 cycles during DRIVE_A -> out_a drops at cycle TO_CNT=400 of DRIVE_A; state IDLE.
- ocd pulse of 1 cycle during DRIVE_B -> both outputs low 2 edges later, fault=1; fault stays set while en=1; en=0 -> IDLE, fault=0; rst during FAULT also clears fault.
